// File: rtl/chess_timer_pkg.sv
// chess_timer_pkg: shared FSM states, player ids, time limits and a binary-to-BCD helper.
package chess_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, TIMEOUT} state_e;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;
    localparam int SECONDS_PER_MINUTE = 60;
    localparam int MAX_MINUTES = 99;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] units;
        tens = v / 7'd10;
        units = v % 7'd10;
        return {tens[3:0], units[3:0]};
    endfunction

endpackage

// File: rtl/player_time_counter.sv
// player_time_counter: one player's min:sec register with countdown, Fischer increment and 99:59 saturation.
module player_time_counter
    import chess_timer_pkg::*;
#(
    parameter int INIT_MINUTES      = 5,
    parameter int INIT_SECONDS      = 0,
    parameter int INCREMENT_SECONDS = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        decrement,
    input  logic        add_increment,
    output logic [6:0]  minutes,
    output logic [5:0]  seconds,
    output logic [15:0] bcd,
    output logic        is_zero
);
    localparam logic [6:0] INIT_M = 7'(INIT_MINUTES);
    localparam logic [5:0] INIT_S = 6'(INIT_SECONDS);
    localparam logic [6:0] MAX_M = 7'(MAX_MINUTES);
    localparam logic [5:0] MAX_S = 6'(SECONDS_PER_MINUTE - 1);
    localparam logic [6:0] SPM = 7'(SECONDS_PER_MINUTE);

    logic [6:0] min_q, min_d, dec_min, inc_min, sum_sec;
    logic [5:0] sec_q, sec_d, dec_sec, inc_sec;
    logic       wrap, sat;

    // Decrement is applied before the increment so a tick and a move on the same edge compose.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (decrement && sec_q != 6'd0)
            dec_sec = sec_q - 6'd1;
        else if (decrement && min_q != 7'd0) begin
            dec_min = min_q - 7'd1;
            dec_sec = MAX_S;
        end
        sum_sec = {1'b0, dec_sec} + 7'(INCREMENT_SECONDS);
        wrap = sum_sec >= SPM;
        inc_min = dec_min + {6'd0, wrap};
        inc_sec = wrap ? 6'(sum_sec - SPM) : sum_sec[5:0];
        sat = inc_min > MAX_M;
        min_d = load ? INIT_M : add_increment ? (sat ? MAX_M : inc_min) : dec_min;
        sec_d = load ? INIT_S : add_increment ? (sat ? MAX_S : inc_sec) : dec_sec;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= INIT_M;
            sec_q <= INIT_S;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign bcd     = {to_bcd(min_q), to_bcd({1'b0, sec_q})};
    assign is_zero = min_q == 7'd0 && sec_q == 6'd0;

endmodule

// File: rtl/chess_clock_timer.sv
// chess_clock_timer: two-player chess clock with prescaler, turn FSM, pause/resume and sticky timeout flags.
module chess_clock_timer
    import chess_timer_pkg::*;
#(
    parameter int CLOCK_FREQUENCY   = 50000000,
    parameter int INIT_MINUTES      = 5,
    parameter int INIT_SECONDS      = 0,
    parameter int INCREMENT_SECONDS = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        move_done,
    output logic        active_player,
    output logic        running,
    output logic [15:0] time_white_bcd,
    output logic [15:0] time_black_bcd,
    output logic        timeout_white,
    output logic        timeout_black
);
    localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLOCK_FREQUENCY - 1);

    state_e        state_q;
    logic [PW-1:0] cnt_q;
    logic          active_q, run_q, to_w_q, to_b_q;
    logic [6:0]    min_w, min_b, act_min;
    logic [5:0]    sec_w, sec_b, act_sec;
    logic          zero_w, zero_b, act_zero;
    logic          tick, flag, move_ok, load;

    assign tick     = state_q == RUNNING && cnt_q == LAST;
    assign act_min  = active_q ? min_b : min_w;
    assign act_sec  = active_q ? sec_b : sec_w;
    assign act_zero = active_q ? zero_b : zero_w;
    // The flag falls on the tick whose decrement lands on 0:00.
    assign flag     = tick && act_min == 7'd0 && (act_zero || act_sec == 6'd1);
    assign move_ok  = state_q == RUNNING && move_done && !pause && !flag;
    assign load     = state_q == IDLE;

    player_time_counter #(
        .INIT_MINUTES(INIT_MINUTES),
        .INIT_SECONDS(INIT_SECONDS),
        .INCREMENT_SECONDS(INCREMENT_SECONDS)
    ) u_white (
        .clock(clock),
        .reset(reset),
        .load(load),
        .decrement(tick && active_q == WHITE),
        .add_increment(move_ok && active_q == WHITE),
        .minutes(min_w),
        .seconds(sec_w),
        .bcd(time_white_bcd),
        .is_zero(zero_w)
    );

    player_time_counter #(
        .INIT_MINUTES(INIT_MINUTES),
        .INIT_SECONDS(INIT_SECONDS),
        .INCREMENT_SECONDS(INCREMENT_SECONDS)
    ) u_black (
        .clock(clock),
        .reset(reset),
        .load(load),
        .decrement(tick && active_q == BLACK),
        .add_increment(move_ok && active_q == BLACK),
        .minutes(min_b),
        .seconds(sec_b),
        .bcd(time_black_bcd),
        .is_zero(zero_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= WHITE;
            run_q    <= 1'b0;
            to_w_q   <= 1'b0;
            to_b_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= RUNNING;
                    cnt_q    <= '0;
                    active_q <= WHITE;
                    run_q    <= 1'b1;
                end
                RUNNING: begin
                    cnt_q <= (tick || move_ok) ? '0 : cnt_q + PW'(1);
                    if (flag) begin
                        state_q <= TIMEOUT;
                        run_q   <= 1'b0;
                        to_w_q  <= to_w_q | (active_q == WHITE);
                        to_b_q  <= to_b_q | (active_q == BLACK);
                    end else if (pause) begin
                        state_q <= PAUSED;
                        run_q   <= 1'b0;
                    end else if (move_ok)
                        active_q <= ~active_q;
                end
                PAUSED: if (start) begin
                    state_q <= RUNNING;
                    run_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign active_player = active_q;
    assign running       = run_q;
    assign timeout_white = to_w_q;
    assign timeout_black = to_b_q;

endmodule

// File: doc/chess_clock_timer.md
Name: chess_clock_timer

Overview:
- Two-player chess clock with parametrised start time and Fischer increment.
- Keeps one min:sec countdown per player; only the side to move counts down.
- Handles turn switching, pause/resume and timeout flagging.
- Outputs per-player BCD digits to the seven-segment decoders and game-over flags to the game controller.

Parameters:
- CLOCK_FREQUENCY, 50000000, clock cycles per second; the internal prescaler tick period.
- INIT_MINUTES, 5, starting minutes per player, 0..99.
- INIT_SECONDS, 0, starting seconds per player, 0..59; INIT_MINUTES:INIT_SECONDS must be nonzero.
- INCREMENT_SECONDS, 0, seconds added to the mover on each move_done, 0..59.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins the game (IDLE) or resumes it (PAUSED)
- pause  in  1  one-cycle pulse; freezes both clocks while RUNNING
- move_done  in  1  one-cycle pulse; active player finished a move
- active_player  out  1  0 = white to move, 1 = black to move
- running  out  1  high only in RUNNING
- time_white_bcd  out  16  white time as {min tens, min units, sec tens, sec units}, 4 bits each
- time_black_bcd  out  16  black time, same format
- timeout_white  out  1  white flag has fallen (sticky)
- timeout_black  out  1  black flag has fallen (sticky)

Behaviour:
- Reset (async, any state): FSM=IDLE, prescaler=0, both players = INIT_MINUTES:INIT_SECONDS, active_player=0, running=0, timeouts=0. BCD outputs show the init time immediately.
- State per player:
  - minutes: 7-bit binary, 0..99.
  - seconds: 6-bit binary, 0..59.
  - BCD outputs are combinational from these registers (value/10, value%10); no extra latency.
- Prescaler: counts 0..CLOCK_FREQUENCY-1 in RUNNING only.
  - tick = 1 for one cycle when count = CLOCK_FREQUENCY-1; count then wraps to 0.
  - Holds its value in PAUSED.
  - Cleared on start-from-IDLE and on every accepted move_done.
- FSM states: IDLE, RUNNING, PAUSED, TIMEOUT.
  - IDLE: start -> RUNNING, white active; pause and move_done ignored.
  - RUNNING: pause -> PAUSED; start ignored.
  - PAUSED: start -> RUNNING with prescaler value preserved; pause and move_done ignored.
  - TIMEOUT: all inputs ignored until reset; running=0; times frozen.
- Tick in RUNNING, applied to the active player:
  - if seconds>0: seconds-1.
  - else if minutes>0: minutes-1, seconds=59.
  - If the result is 0:00: the same edge enters TIMEOUT and sets the active player's timeout flag.
- Accepted move_done in RUNNING:
  - Mover gets seconds+INCREMENT_SECONDS; if the sum >=60, subtract 60 and add 1 to minutes.
  - Saturate at 99:59.
  - active_player toggles on the same edge.
- Simultaneous events, in priority order:
  - Pause beats move_done: the move is ignored and no increment is given.
  - Tick + move_done: decrement first, then increment, then toggle.
  - If that decrement reaches 0:00, TIMEOUT wins and the move is ignored.
  - start + pause in IDLE: start wins; pause ignored.
- Latency: all state changes are visible one cycle after the qualifying input or tick.

Decomposition:
- Shared package chess_timer_pkg holds:
  - FSM state enum: IDLE, RUNNING, PAUSED, TIMEOUT.
  - Constants WHITE=0 and BLACK=1.
  - Constants SECONDS_PER_MINUTE=60 and MAX_MINUTES=99.
- Sub-module player_time_counter, instantiated twice:
  - inputs: load, decrement, add_increment.
  - outputs: minutes, seconds, BCD digits, is_zero.
- Prescaler and FSM live in the top module.

Test Plan (CLOCK_FREQUENCY=4 unless stated):
- Reset: outputs 16'h0500 on both players, active_player=0, running=0, timeouts=0.
- Countdown: start, wait 8 cycles -> white = 16'h0458, black = 16'h0500, running=1.
- Move switching: start; after 4 cycles move_done -> white 16'h0459 (with INCREMENT_SECONDS=2: 16'h0501), active_player=1; black then decrements and white holds.
- Pause: pause mid-second for 20 cycles, then start -> times unchanged during pause, and the next tick arrives after the preserved remaining count.
- Timeout (INIT 0:02): start, 8 cycles -> white 16'h0000, timeout_white=1, running=0; later start and move_done produce no change.
- Edge cases, each checked on its own bench run:
  - Reset asserted mid-RUNNING -> immediate IDLE values.
  - Tick + move_done in the same cycle -> decrement, then increment, then toggle, as specified.
  - Increment at 99:59 -> saturates at 99:59.
